// File: rtl/seg7_pkg.sv
// Shared types, constants and segment decode for the seven-segment timer display.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_t;

    localparam int          NUM_DIGITS = 4;
    localparam logic [15:0] SAT_MAX    = 16'd9999;

    // Active-low, bit order gfedcba
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_timer_display_if.sv
// Seconds-count input and multiplexed display outputs of the timer display stage.
interface seg7_timer_display_if;
    logic [15:0] count;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        busy;

    modport master (output count, input seg, dp, an, busy);
    modport slave  (input count, output seg, dp, an, busy);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 converter: 16 shift iterations, then one LOAD cycle flagged by done_o.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic        clock_100Mhz,
    input  logic        reset,
    input  logic        start_i,
    input  logic [15:0] value_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] bcd_o
);

    state_t      state_q, state_d;
    logic [3:0]  iter_q, iter_d;
    logic [31:0] shreg_q, shreg_d;
    logic [15:0] bcd_adj;

    always_comb begin
        bcd_adj = shreg_q[31:16];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (shreg_q[16 + 4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = shreg_q[16 + 4*i +: 4] + 4'd3;
        end
    end

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    shreg_d = {16'd0, value_i};
                    iter_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d = {bcd_adj, shreg_q[15:0]} << 1;
                iter_d  = iter_q + 4'd1;
                if (iter_q == 4'd15)
                    state_d = LOAD;
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the shift register is reset too, so an aborted conversion never leaves stale digits behind.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            iter_q  <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            shreg_q <= shreg_d;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == LOAD);
    assign bcd_o  = shreg_q[31:16];

endmodule

// File: rtl/seg7_timer_display.sv
// Elapsed-seconds display: change detect, saturation to 9999, BCD conversion and 4-digit scan.
// Optional: SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros in digits 3..1.
module seg7_timer_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
)
(
    input  logic                 clock_100Mhz,
    input  logic                 reset,
    seg7_timer_display_if.slave  disp
);

    localparam int               CNT_W        = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [15:0]                 last_count_q, last_count_d;
    logic                        ovf_pend_q, ovf_pend_d;
    logic [NUM_DIGITS-1:0][3:0]  digits_q, digits_d;
    logic                        ovf_q, ovf_d;
    logic [CNT_W-1:0]            refresh_q, refresh_d;
    logic [1:0]                  idx_q, idx_d;
    logic [3:0]                  an_q, an_d;
    logic [6:0]                  seg_q, seg_d;
    logic                        dp_q, dp_d;

    logic                        conv_start, conv_busy, conv_done;
    logic [15:0]                 conv_value, conv_bcd;
    logic [NUM_DIGITS-1:0]       blank;

    assign conv_start = !conv_busy && (disp.count != last_count_q);
    assign conv_value = (disp.count > SAT_MAX) ? SAT_MAX : disp.count;

    bin2bcd_seq u_bin2bcd (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .start_i      (conv_start),
        .value_i      (conv_value),
        .busy_o       (conv_busy),
        .done_o       (conv_done),
        .bcd_o        (conv_bcd)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit is blank only if it and every digit above it are zero; the ones digit always shows.
    assign blank[3] = (digits_q[3] == 4'd0);
    assign blank[2] = blank[3] && (digits_q[2] == 4'd0);
    assign blank[1] = blank[2] && (digits_q[1] == 4'd0);
    assign blank[0] = 1'b0;
`else
    assign blank = '0;
`endif

    always_comb begin
        last_count_d = last_count_q;
        ovf_pend_d   = ovf_pend_q;
        digits_d     = digits_q;
        ovf_d        = ovf_q;
        if (conv_start) begin
            last_count_d = disp.count;
            ovf_pend_d   = (disp.count > SAT_MAX);
        end
        if (conv_done) begin
            digits_d = conv_bcd;
            ovf_d    = ovf_pend_q;
        end

        idx_d = idx_q;
        if (refresh_q == REFRESH_LAST) begin
            refresh_d = '0;
            idx_d     = idx_q + 2'd1;
        end else begin
            refresh_d = refresh_q + CNT_W'(1);
        end

        an_d  = ~(4'b0001 << idx_q);
        seg_d = blank[idx_q] ? SEG_BLANK : seg_decode(digits_q[idx_q]);
        dp_d  = !((idx_q == 2'd3) && ovf_q);
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            last_count_q <= '0;
            ovf_pend_q   <= 1'b0;
            digits_q     <= '0;
            ovf_q        <= 1'b0;
            refresh_q    <= '0;
            idx_q        <= '0;
            an_q         <= 4'b1110;
            seg_q        <= SEG_0;
            dp_q         <= 1'b1;
        end else begin
            last_count_q <= last_count_d;
            ovf_pend_q   <= ovf_pend_d;
            digits_q     <= digits_d;
            ovf_q        <= ovf_d;
            refresh_q    <= refresh_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign disp.an   = an_q;
    assign disp.seg  = seg_q;
    assign disp.dp   = dp_q;
    assign disp.busy = conv_busy;

endmodule

// File: tb/tb_seg7_timer_display.sv
// Directed bench for seg7_timer_display with a short refresh divider.
module tb_seg7_timer_display;

    localparam int REFRESH_DIV = 4;

    logic clock_100Mhz = 1'b0;
    logic reset;

    seg7_timer_display_if dut_if ();

    seg7_timer_display #(.REFRESH_DIV(REFRESH_DIV)) dut (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .disp         (dut_if)
    );

    always #5 clock_100Mhz = ~clock_100Mhz;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [6:0] seg_table [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                   7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    function automatic logic [6:0] expected_seg(input int value, input int pos);
        int scale = 1;
        int d;
        for (int i = 0; i < pos; i++) scale = scale * 10;
        d = (value / scale) % 10;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (pos > 0 && value < scale) return 7'b1111111;
`endif
        return seg_table[d];
    endfunction

    task automatic tick();
        @(posedge clock_100Mhz);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (dut_if.busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks_total++;
        if (dut_if.busy !== 1'b0)
            $display("FAIL %s_idle_timeout busy=%b expected=0", name, dut_if.busy);
        else
            checks_passed++;
    endtask

    task automatic scan_display(input string name, input int value, input bit ovf);
        logic [3:0] prev_an;
        int         run;
        bit         seen_edge;
        int         pos;
        logic       exp_dp;
        prev_an   = dut_if.an;
        run       = 0;
        seen_edge = 0;
        for (int c = 0; c < 6 * REFRESH_DIV; c++) begin
            case (dut_if.an)
                4'b1110: pos = 0;
                4'b1101: pos = 1;
                4'b1011: pos = 2;
                4'b0111: pos = 3;
                default: pos = -1;
            endcase
            checks_total++;
            if (pos < 0) begin
                $display("FAIL %s_an_onehot an=%b expected one low bit", name, dut_if.an);
            end else begin
                checks_passed++;
                checks_total++;
                if (dut_if.seg !== expected_seg(value, pos))
                    $display("FAIL %s_seg pos=%0d seg=%b expected=%b", name, pos, dut_if.seg, expected_seg(value, pos));
                else
                    checks_passed++;
                exp_dp = !(pos == 3 && ovf);
                checks_total++;
                if (dut_if.dp !== exp_dp)
                    $display("FAIL %s_dp pos=%0d dp=%b expected=%b", name, pos, dut_if.dp, exp_dp);
                else
                    checks_passed++;
            end
            if (dut_if.an !== prev_an) begin
                if (seen_edge) begin
                    checks_total++;
                    if (run !== REFRESH_DIV)
                        $display("FAIL %s_slot_len len=%0d expected=%0d", name, run, REFRESH_DIV);
                    else
                        checks_passed++;
                    checks_total++;
                    if (dut_if.an !== {prev_an[2:0], prev_an[3]})
                        $display("FAIL %s_scan_order an=%b expected=%b", name, dut_if.an, {prev_an[2:0], prev_an[3]});
                    else
                        checks_passed++;
                end
                seen_edge = 1;
                run       = 1;
                prev_an   = dut_if.an;
            end else begin
                run++;
            end
            tick();
        end
    endtask

    // Launch a conversion, confirm busy rises, and wait until the new digits reach the outputs.
    task automatic convert(input string name, input logic [15:0] value);
        dut_if.count = value;
        tick();
        checks_total++;
        if (dut_if.busy !== 1'b1)
            $display("FAIL %s_busy_rise busy=%b expected=1", name, dut_if.busy);
        else
            checks_passed++;
        wait_idle(name);
        tick();
    endtask

    task automatic test_reset();
        checks_total++;
        if (dut_if.an !== 4'b1110 || dut_if.seg !== 7'b1000000 || dut_if.dp !== 1'b1 || dut_if.busy !== 1'b0)
            $display("FAIL reset_held an=%b seg=%b dp=%b busy=%b expected 1110/1000000/1/0",
                     dut_if.an, dut_if.seg, dut_if.dp, dut_if.busy);
        else
            checks_passed++;
        reset = 1'b0;
        tick();
        checks_total++;
        if (dut_if.an !== 4'b1110 || dut_if.seg !== 7'b1000000 || dut_if.dp !== 1'b1)
            $display("FAIL reset_release an=%b seg=%b dp=%b expected 1110/1000000/1",
                     dut_if.an, dut_if.seg, dut_if.dp);
        else
            checks_passed++;
        for (int i = 0; i < 8; i++) begin
            checks_total++;
            if (dut_if.busy !== 1'b0)
                $display("FAIL reset_no_conv cycle=%0d busy=%b expected=0", i, dut_if.busy);
            else
                checks_passed++;
            tick();
        end
        scan_display("reset_scan", 0, 1'b0);
    endtask

    task automatic test_conversion();
        int n = 0;
        int guard = 0;
        dut_if.count = 16'd1234;
        tick();
        while (guard < 100) begin
            if (dut_if.busy === 1'b1) n++;
            else if (n > 0) break;
            tick();
            guard++;
        end
        checks_total++;
        if (n !== 17)
            $display("FAIL conv_busy_len cycles=%0d expected=17", n);
        else
            checks_passed++;
        tick();
        scan_display("conv_1234", 1234, 1'b0);
    endtask

    task automatic test_saturation();
        convert("sat", 16'd12000);
        scan_display("sat_9999", 9999, 1'b1);
    endtask

    task automatic test_back_to_back();
        dut_if.count = 16'd1234;
        repeat (5) tick();
        dut_if.count = 16'd1235;
        wait_idle("b2b_first");
        tick();
        checks_total++;
        if (dut_if.busy !== 1'b1)
            $display("FAIL b2b_restart busy=%b expected=1", dut_if.busy);
        else
            checks_passed++;
        wait_idle("b2b_second");
        tick();
        scan_display("b2b_1235", 1235, 1'b0);
    endtask

    task automatic test_reset_abort();
        dut_if.count = 16'd4321;
        repeat (9) tick();
        checks_total++;
        if (dut_if.busy !== 1'b1)
            $display("FAIL abort_mid_conv busy=%b expected=1", dut_if.busy);
        else
            checks_passed++;
        reset = 1'b1;
        #1;
        checks_total++;
        if (dut_if.an !== 4'b1110 || dut_if.seg !== 7'b1000000 || dut_if.dp !== 1'b1 || dut_if.busy !== 1'b0)
            $display("FAIL abort_outputs an=%b seg=%b dp=%b busy=%b expected 1110/1000000/1/0",
                     dut_if.an, dut_if.seg, dut_if.dp, dut_if.busy);
        else
            checks_passed++;
        dut_if.count = 16'd0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        checks_total++;
        if (dut_if.busy !== 1'b0)
            $display("FAIL abort_idle busy=%b expected=0", dut_if.busy);
        else
            checks_passed++;
        scan_display("abort_0000", 0, 1'b0);
    endtask

    task automatic test_small_value();
        convert("small", 16'd7);
        scan_display("small_7", 7, 1'b0);
    endtask

    initial begin
        reset        = 1'b1;
        dut_if.count = 16'd0;
        repeat (3) tick();
        test_reset();
        test_conversion();
        test_saturation();
        test_back_to_back();
        test_reset_abort();
        test_small_value();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/seg7_timer_display.md
# seg7_timer_display

Downstream display stage for the crane-game elapsed-seconds counter. Consumes the free-running 16-bit seconds count, converts it to four BCD digits with a sequential shift-and-add-3 converter, and time-multiplexes the digits onto a 4-digit common-anode seven-segment display. Values above 9999 saturate to 9999, and an overflow indicator is lit.

## Interface
- REFRESH_DIV, 100000: clocks per digit slot; default gives 1 kHz digit rate and 250 Hz frame rate; legal range ≥ 2.
- clock_100Mhz  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high.
- count  in  16  unsigned seconds value from the seconds counter; may change on any clock.
- seg  out  7  segment cathodes, active-low; seg[0]=a … seg[6]=g.
- dp  out  1  decimal point, active-low.
- an  out  4  digit anodes, active-low one-hot; an[0] = rightmost (ones) digit.
- busy  out  1  high while a conversion is in progress.

## Operation
- Change detect: register last_count (reset 0). In IDLE, when count != last_count, latch count into last_count and the converter input, then go to SHIFT.
- Saturation: if the latched value > 9999, convert 9999 and set ovf. Otherwise clear ovf. ovf is written together with the digits.
- FSM states:
  - IDLE: waits for a change.
  - SHIFT: exactly 16 iterations. In each iteration, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1.
  - LOAD: writes the 4 BCD digits and ovf into the display registers, then returns to IDLE.
- busy is high in SHIFT and LOAD.
- Changes to count during SHIFT/LOAD are not lost. On return to IDLE, the comparison against last_count triggers a new conversion. Intermediate values may be skipped; the final value is always shown.
- Scan: refresh counter counts 0..REFRESH_DIV-1 and wraps. On wrap, digit index advances 0→1→2→3→0.
- Output registers are updated every clock from the digit index and the display registers:
  - an = ~(1 << idx).
  - seg = decode(digit[idx]), or blank (7'b1111111) when the digit is blanked.
  - dp is low only when idx==3 and ovf=1.
- Decode patterns, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Non-BCD codes decode to blank. They are unreachable by construction.

## Timing
- Reset values:
  - State: IDLE, last_count=0, digits=0000, ovf=0, idx=0, refresh counter=0.
  - Outputs: an=4'b1110, seg=7'b1000000, dp=1, busy=0.
- Latency, with edge E0 being the edge that latches a changed count:
  - busy is high from after E0 until after E17.
  - Shifts occur at E1..E16.
  - Display registers are written at E17.
  - seg/an reflect the new digit no earlier than E18, the registered output stage.
- A count change at E17 (the LOAD cycle) is detected at E18, in IDLE.
- Reset asserted mid-conversion aborts immediately to the reset values. No partial digits ever reach the display.
- Digit slot length is exactly REFRESH_DIV clocks. an changes exactly at slot boundaries, and never two anodes are low at once.

## Configuration
- SEG7_LEADING_ZERO_BLANK_EN:
  - Defined: leading zero digits in positions 3..1 are blanked (seg=7'b1111111, anode still scanned). Digit 0 is never blanked, so a value of 0 shows a single "0".
  - Undefined: all four digits are always shown, e.g. 0007.
- ovf forces 9999, so it has no blanking interaction.

## Structure
- Package seg7_pkg:
  - FSM state enum (IDLE, SHIFT, LOAD).
  - NUM_DIGITS=4, SAT_MAX=16'd9999.
  - Segment pattern constants and SEG_BLANK.
  - BCD-to-segment decode function.
- Sub-module bin2bcd_seq:
  - Holds the FSM, the shift counter, and the {bcd, bin} shift register.
  - Interface: start/value in; busy/done/bcd[15:0] out.
- Top level holds change detect, saturation, display registers, refresh counter and the output registers.

## Test plan
- Reset release, count=0 → an=1110, seg=1000000, dp=1, busy=0; no conversion starts.
- REFRESH_DIV=4, count 0→1234 → busy high for 17 cycles; digits then scan 4,3,2,1 on an 1110,1101,1011,0111, each slot 4 clocks.
- count=12000 → display 9999; dp=0 only while an=0111.
- count=1234, then 1235 five clocks later → second conversion starts automatically after LOAD; final display 1235.
- Reset pulse at SHIFT iteration 8 of a 4321 conversion → outputs return to reset values; display shows 0000; busy=0.
- count=7 with SEG7_LEADING_ZERO_BLANK_EN → digits 3..1 seg=1111111, digit 0 seg=1111000. Without the macro → 0007.
